// File: rtl/risc_pkg.sv
// Shared RISC pipeline definitions: opcodes, instruction field positions,
// instruction width and the fetch-queue entry layout.
package risc_pkg;

  localparam int INSTR_W = 32;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;
  localparam int RS_MSB  = 25;
  localparam int RS_LSB  = 21;
  localparam int RT_MSB  = 20;
  localparam int RT_LSB  = 16;
  localparam int RD_MSB  = 15;
  localparam int RD_LSB  = 11;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

  typedef logic [5:0] opcode_t;

  localparam opcode_t ADD   = 6'b000000;
  localparam opcode_t SUB   = 6'b000001;
  localparam opcode_t AND   = 6'b000010;
  localparam opcode_t OR    = 6'b000011;
  localparam opcode_t SLT   = 6'b000100;
  localparam opcode_t MUL   = 6'b000101;
  localparam opcode_t LW    = 6'b001000;
  localparam opcode_t SW    = 6'b001001;
  localparam opcode_t ADDI  = 6'b001010;
  localparam opcode_t SUBI  = 6'b001011;
  localparam opcode_t SLTI  = 6'b001100;
  localparam opcode_t BNEQZ = 6'b001101;
  localparam opcode_t BEQZ  = 6'b001110;
  localparam opcode_t HLT   = 6'b111111;

  typedef struct packed {
    logic [INSTR_W-1:0] ir;
    logic [31:0]        npc;
  } fetch_entry_t;

  function automatic logic is_hlt(input logic [INSTR_W-1:0] ir);
    logic [5:0] opc;
    opc = ir[OPC_MSB:OPC_LSB];
    is_hlt = (opc == HLT);
  endfunction

endpackage

// File: rtl/risc_fetch_fifo.sv
// Prefetch FIFO of {IR, NPC} entries: circular storage with head/tail
// pointers, occupancy count and a synchronous flush that empties it in one cycle.
module risc_fetch_fifo
  import risc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk1,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  fetch_entry_t             push_data,
  output fetch_entry_t             head_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  fetch_entry_t    mem_r [DEPTH];
  logic [PW-1:0]   head_r;
  logic [PW-1:0]   tail_r;
  logic [PW:0]     count_r;

  // Entry storage; a flushed push is dropped along with the rest of the queue.
  always_ff @(posedge clk1) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (push && !flush) begin
      mem_r[tail_r] <= push_data;
    end else begin
      mem_r[tail_r] <= mem_r[tail_r];
    end
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk1) begin
    if (rst || flush) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else begin
      if (push) begin
        tail_r <= tail_r + PW'(1);
      end else begin
        tail_r <= tail_r;
      end
      if (pop) begin
        head_r <= head_r + PW'(1);
      end else begin
        head_r <= head_r;
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + (PW+1)'(1);
        2'b01:   count_r <= count_r - (PW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign head_data = mem_r[head_r];
  assign count     = count_r;

endmodule

// File: rtl/risc_fetch_queue.sv
// Instruction fetch unit with prefetch queue feeding ID over valid/ready.
// Optional stop-on-HLT behaviour is enabled by defining RISC_FETCH_HALT_DETECT_EN.
module risc_fetch_queue
  import risc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 10
) (
  input  logic          clk1,
  input  logic          rst,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic [31:0]   imem_rdata,
  input  logic          redirect_valid,
  input  logic [31:0]   redirect_pc,
  input  logic          halt,
  input  logic          id_ready,
  output logic          id_valid,
  output logic [31:0]   IF_ID_IR,
  output logic [31:0]   IF_ID_NPC,
  output logic [31:0]   PC
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = DEPTH[CW:0];

  logic [31:0]   pc_r;
  logic [31:0]   infl_pc_r;
  logic          infl_r;
  logic          stop_s;
  logic          pop_s;
  logic          push_s;
  logic          req_s;
  logic          id_valid_s;
  logic [CW-1:0] count_s;
  logic [CW:0]   credit_s;
  fetch_entry_t  push_data_s;
  fetch_entry_t  head_s;

  // Handshake and credit: a request is allowed only if its response is sure to fit next cycle.
  always_comb begin
    id_valid_s  = (count_s != '0);
    pop_s       = id_valid_s && id_ready && !redirect_valid;
    push_s      = infl_r && !redirect_valid && !stop_s;
    credit_s    = {1'b0, count_s} + {{CW{1'b0}}, infl_r} - {{CW{1'b0}}, pop_s};
    req_s       = !rst && !halt && !redirect_valid && !stop_s && (credit_s < DEPTH_C);
    push_data_s = '{ir: imem_rdata, npc: infl_pc_r + 32'd1};
  end

  // PC and the single in-flight request; redirect discards whatever is outstanding.
  always_ff @(posedge clk1) begin
    if (rst) begin
      pc_r      <= 32'd0;
      infl_r    <= 1'b0;
      infl_pc_r <= 32'd0;
    end else if (redirect_valid) begin
      pc_r      <= redirect_pc;
      infl_r    <= 1'b0;
      infl_pc_r <= infl_pc_r;
    end else if (req_s) begin
      pc_r      <= pc_r + 32'd1;
      infl_r    <= 1'b1;
      infl_pc_r <= pc_r;
    end else begin
      pc_r      <= pc_r;
      infl_r    <= 1'b0;
      infl_pc_r <= infl_pc_r;
    end
  end

`ifdef RISC_FETCH_HALT_DETECT_EN
  logic stop_r;

  // Sticky stop once an HLT enters the queue; only a redirect or reset restarts fetch.
  always_ff @(posedge clk1) begin
    if (rst) begin
      stop_r <= 1'b0;
    end else if (redirect_valid) begin
      stop_r <= 1'b0;
    end else if (push_s && is_hlt(imem_rdata)) begin
      stop_r <= 1'b1;
    end else begin
      stop_r <= stop_r;
    end
  end

  assign stop_s = stop_r;
`else
  assign stop_s = 1'b0;
`endif

  risc_fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk1      (clk1),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (push_s),
    .pop       (pop_s),
    .push_data (push_data_s),
    .head_data (head_s),
    .count     (count_s)
  );

  // Head presentation; stale storage is masked so ID sees zeros when nothing is valid.
  always_comb begin
    if (id_valid_s) begin
      IF_ID_IR  = head_s.ir;
      IF_ID_NPC = head_s.npc;
    end else begin
      IF_ID_IR  = 32'd0;
      IF_ID_NPC = 32'd0;
    end
  end

  assign imem_req  = req_s;
  assign imem_addr = pc_r[AW-1:0];
  assign id_valid  = id_valid_s;
  assign PC        = pc_r;

endmodule
